sprite_line_scheduler: RTL and testbench

//  Per-scanline sprite scheduler for the playfield renderer. On each line_start (hblank) it

---
 rtl/sprite_line_scheduler.sv | 174 +++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. On each line_start it snapshots the sprite positions and
// fetches the mask rows of the sprites that cover the next line. The resulting slots stay stable until the next commit.
module sprite_line_scheduler #(
    parameter int TILE_SIZE   = 20,
    parameter int ROW_LOG2    = 5,
    parameter int W_LOG2      = 10,
    parameter int H_LOG2      = 10,
    parameter int NUM_SPRITES = 5,
    parameter int MAX_SLOTS   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            line_start,
    input  logic [H_LOG2-1:0]               next_y,
    input  logic [NUM_SPRITES*W_LOG2-1:0]   sprite_x,
    input  logic [NUM_SPRITES*H_LOG2-1:0]   sprite_y,
    input  logic [NUM_SPRITES-1:0]          sprite_frame,
    output logic                            rom_req,
    output logic [2:0]                      rom_sprite,
    output logic [ROW_LOG2-1:0]             rom_row,
    output logic                            rom_frame,
    input  logic                            rom_ack,
    input  logic [TILE_SIZE-1:0]            rom_data,
    output logic [MAX_SLOTS-1:0]            slot_valid,
    output logic [MAX_SLOTS*3-1:0]          slot_id,
    output logic [MAX_SLOTS*W_LOG2-1:0]     slot_x,
    output logic [MAX_SLOTS*TILE_SIZE-1:0]  slot_mask,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic                            missed_line
);

    localparam int CNT_W = $clog2(MAX_SLOTS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, COMMIT} state_t;

    state_t                 state;
    logic [2:0]             idx;
    logic [CNT_W-1:0]       count;
    logic                   ovf_shadow;

    logic [H_LOG2-1:0]      snap_line;
    logic [W_LOG2-1:0]      snap_x [NUM_SPRITES];
    logic [H_LOG2-1:0]      snap_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] snap_frame;

    logic [MAX_SLOTS-1:0]   shadow_valid;
    logic [2:0]             shadow_id   [MAX_SLOTS];
    logic [W_LOG2-1:0]      shadow_x    [MAX_SLOTS];
    logic [TILE_SIZE-1:0]   shadow_mask [MAX_SLOTS];

    logic [H_LOG2:0]        line_ext;
    logic [H_LOG2:0]        top_ext;
    logic                   hit;
    logic                   last;
    logic                   full;

    // One extra bit so sprites near the bottom of the y range cannot wrap into row 0.
    always_comb begin
        line_ext = {1'b0, snap_line};
        top_ext  = {1'b0, snap_y[idx]};
        hit      = (line_ext >= top_ext) && (line_ext < top_ext + (H_LOG2+1)'(TILE_SIZE));
        last     = (idx == 3'(NUM_SPRITES - 1));
        full     = (count == CNT_W'(MAX_SLOTS));
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            count        <= '0;
            ovf_shadow   <= 1'b0;
            snap_line    <= '0;
            snap_frame   <= '0;
            rom_req      <= 1'b0;
            rom_sprite   <= '0;
            rom_row      <= '0;
            rom_frame    <= 1'b0;
            slot_valid   <= '0;
            slot_id      <= '0;
            slot_x       <= '0;
            slot_mask    <= '0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            missed_line  <= 1'b0;
            shadow_valid <= '0;
            // NOTE: the small shadow/snapshot arrays are reset on purpose so that a line
            // aborted by reset can never leak stale entries into a later commit.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                snap_x[i] <= '0;
                snap_y[i] <= '0;
            end
            for (int i = 0; i < MAX_SLOTS; i++) begin
                shadow_id[i]   <= '0;
                shadow_x[i]    <= '0;
                shadow_mask[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (line_start && state != IDLE)
                missed_line <= 1'b1;

            case (state)
                IDLE: begin
                    if (line_start) begin
                        snap_line    <= next_y;
                        snap_frame   <= sprite_frame;
                        for (int i = 0; i < NUM_SPRITES; i++) begin
                            snap_x[i] <= sprite_x[i*W_LOG2 +: W_LOG2];
                            snap_y[i] <= sprite_y[i*H_LOG2 +: H_LOG2];
                        end
                        idx          <= '0;
                        count        <= '0;
                        ovf_shadow   <= 1'b0;
                        shadow_valid <= '0;
                        state        <= SCAN;
                    end
                end

                SCAN: begin
                    if (hit && !full) begin
                        rom_req    <= 1'b1;
                        rom_sprite <= idx;
                        rom_row    <= ROW_LOG2'(snap_line - snap_y[idx]);
                        rom_frame  <= snap_frame[idx];
                        state      <= FETCH;
                    end else begin
                        if (hit)
                            ovf_shadow <= 1'b1;
                        if (last)
                            state <= COMMIT;
                        else
                            idx <= idx + 3'd1;
                    end
                end

                FETCH: begin
                    if (rom_ack) begin
                        rom_req             <= 1'b0;
                        shadow_valid[count] <= 1'b1;
                        shadow_id[count]    <= idx;
                        shadow_x[count]     <= snap_x[idx];
                        shadow_mask[count]  <= rom_data;
                        count               <= count + CNT_W'(1);
                        if (last) begin
                            state <= COMMIT;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SCAN;
                        end
                    end
                end

                COMMIT: begin
                    slot_valid <= shadow_valid;
                    for (int i = 0; i < MAX_SLOTS; i++) begin
                        slot_id[i*3 +: 3]                <= shadow_id[i];
                        slot_x[i*W_LOG2 +: W_LOG2]       <= shadow_x[i];
                        slot_mask[i*TILE_SIZE +: TILE_SIZE] <= shadow_mask[i];
                    end
                    overflow <= ovf_shadow;
                    done     <= 1'b1;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: a ROM responder with programmable ack delay,
// a fetch log, and hand-computed expectations for each scanline scenario.
module tb_sprite_line_scheduler;

    localparam int TILE_SIZE   = 20;
    localparam int ROW_LOG2    = 5;
    localparam int W_LOG2      = 10;
    localparam int H_LOG2      = 10;
    localparam int NUM_SPRITES = 5;
    localparam int MAX_SLOTS   = 4;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            line_start;
    logic [H_LOG2-1:0]               next_y;
    logic [NUM_SPRITES*W_LOG2-1:0]   sprite_x;
    logic [NUM_SPRITES*H_LOG2-1:0]   sprite_y;
    logic [NUM_SPRITES-1:0]          sprite_frame;
    logic                            rom_req;
    logic [2:0]                      rom_sprite;
    logic [ROW_LOG2-1:0]             rom_row;
    logic                            rom_frame;
    logic                            rom_ack;
    logic [TILE_SIZE-1:0]            rom_data;
    logic [MAX_SLOTS-1:0]            slot_valid;
    logic [MAX_SLOTS*3-1:0]          slot_id;
    logic [MAX_SLOTS*W_LOG2-1:0]     slot_x;
    logic [MAX_SLOTS*TILE_SIZE-1:0]  slot_mask;
    logic                            busy;
    logic                            done;
    logic                            overflow;
    logic                            missed_line;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_line_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .line_start   (line_start),
        .next_y       (next_y),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_frame (sprite_frame),
        .rom_req      (rom_req),
        .rom_sprite   (rom_sprite),
        .rom_row      (rom_row),
        .rom_frame    (rom_frame),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .slot_valid   (slot_valid),
        .slot_id      (slot_id),
        .slot_x       (slot_x),
        .slot_mask    (slot_mask),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .missed_line  (missed_line)
    );

    // Mask ROM model: recognisable pattern built from the request fields.
    function automatic logic [TILE_SIZE-1:0] exp_mask(logic [2:0] s, logic f, logic [4:0] r);
        return {f, s, 11'h5A5, r};
    endfunction

    int   ack_delay = 0;
    logic rom_en    = 1'b1;
    int   wait_cnt  = 0;

    always @(posedge clk) begin
        if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    assign rom_ack  = rom_en && rom_req && (wait_cnt >= ack_delay);
    assign rom_data = exp_mask(rom_sprite, rom_frame, rom_row);

    // Request monitor: fetch log, request-cycle count, stability of held requests.
    int         fetch_total = 0;
    logic [2:0] fetch_id  [64];
    logic [4:0] fetch_row [64];
    int         req_cycles = 0;
    int         unstable   = 0;
    logic       prev_req   = 1'b0;
    logic [4:0] prev_row   = '0;
    logic [2:0] prev_sprite = '0;

    always @(posedge clk) begin
        if (rom_req) req_cycles <= req_cycles + 1;
        if (rom_req && prev_req && (rom_row !== prev_row || rom_sprite !== prev_sprite))
            unstable <= unstable + 1;
        prev_req    <= rom_req;
        prev_row    <= rom_row;
        prev_sprite <= rom_sprite;
        if (rom_req && rom_ack && fetch_total < 64) begin
            fetch_id[fetch_total]  <= rom_sprite;
            fetch_row[fetch_total] <= rom_row;
            fetch_total            <= fetch_total + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sprite(input int i, input int x, input int y);
        sprite_x[i*W_LOG2 +: W_LOG2] = W_LOG2'(x);
        sprite_y[i*H_LOG2 +: H_LOG2] = H_LOG2'(y);
    endtask

    task automatic park_all();
        for (int i = 0; i < NUM_SPRITES; i++) set_sprite(i, 0, 300);
        sprite_frame = '0;
    endtask

    task automatic start_line(input int y);
        next_y     = H_LOG2'(y);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    // Returns latency from the line_start cycle to the done cycle; caps the wait.
    task automatic wait_done(input int already, output int lat);
        int n;
        n = already;
        while (!done && n < 100) begin
            step();
            n++;
        end
        lat = n + 1;
    endtask

    int lat;
    int base_f;
    int base_r;
    int base_u;
    int extra_done;

    initial begin
        reset        = 1'b1;
        line_start   = 1'b0;
        next_y       = '0;
        sprite_x     = '0;
        sprite_y     = '0;
        sprite_frame = '0;
        step();
        step();
        check("reset_busy",     busy,        1'b0);
        check("reset_done",     done,        1'b0);
        check("reset_req",      rom_req,     1'b0);
        check("reset_valid",    slot_valid,  4'b0000);
        check("reset_overflow", overflow,    1'b0);
        check("reset_missed",   missed_line, 1'b0);
        reset = 1'b0;
        step();

        // No sprite on the line: pure scan latency, no ROM traffic.
        park_all();
        base_r = req_cycles;
        start_line(100);
        check("empty_busy", busy, 1'b1);
        wait_done(0, lat);
        check("empty_latency", lat, 7);
        check("empty_valid", slot_valid, 4'b0000);
        check("empty_no_req", req_cycles - base_r, 0);
        check("empty_idle_in_done", busy, 1'b0);

        // line_start in the done cycle is accepted as a fresh line.
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("done_pulse_one_cycle", done, 1'b0);
        check("done_cycle_accept_busy", busy, 1'b1);
        wait_done(0, lat);
        check("done_cycle_accept_latency", lat, 7);
        check("done_cycle_no_missed", missed_line, 1'b0);

        // Single hit: sprite 2 at y=95, row 5, frame 1.
        park_all();
        set_sprite(2, 40, 95);
        sprite_frame = 5'b00100;
        base_f = fetch_total;
        start_line(100);
        wait_done(0, lat);
        check("single_latency", lat, 8);
        check("single_fetches", fetch_total - base_f, 1);
        check("single_rom_sprite", fetch_id[base_f], 3'd2);
        check("single_rom_row", fetch_row[base_f], 5'd5);
        check("single_valid", slot_valid, 4'b0001);
        check("single_id", slot_id[2:0], 3'd2);
        check("single_x", slot_x[9:0], 10'd40);
        check("single_mask", slot_mask[19:0], exp_mask(3'd2, 1'b1, 5'd5));
        check("single_overflow", overflow, 1'b0);

        // All five overlap: ids 0..3 fetched, id 4 dropped with overflow.
        for (int i = 0; i < NUM_SPRITES; i++) set_sprite(i, 100*i + 7, 90 + i);
        sprite_frame = '0;
        base_f = fetch_total;
        start_line(100);
        wait_done(0, lat);
        check("full_latency", lat, 11);
        check("full_fetches", fetch_total - base_f, 4);
        check("full_first_id", fetch_id[base_f], 3'd0);
        check("full_last_id", fetch_id[base_f+3], 3'd3);
        check("full_valid", slot_valid, 4'b1111);
        check("full_ids", slot_id, {3'd3, 3'd2, 3'd1, 3'd0});
        check("full_x1", slot_x[19:10], 10'd107);
        check("full_mask3", slot_mask[79:60], exp_mask(3'd3, 1'b0, 5'd7));
        check("full_overflow", overflow, 1'b1);

        // Bottom edge: row 19 hits, clears previous overflow.
        park_all();
        set_sprite(0, 12, 200);
        base_f = fetch_total;
        start_line(219);
        wait_done(0, lat);
        check("row19_valid", slot_valid, 4'b0001);
        check("row19_row", fetch_row[base_f], 5'd19);
        check("row19_mask", slot_mask[19:0], exp_mask(3'd0, 1'b0, 5'd19));
        check("row19_overflow_cleared", overflow, 1'b0);

        // One line below the sprite: miss.
        start_line(220);
        wait_done(0, lat);
        check("row20_valid", slot_valid, 4'b0000);
        check("row20_latency", lat, 7);

        // Sprite near the bottom of the y range must not wrap onto line 5.
        set_sprite(0, 12, 1015);
        start_line(5);
        wait_done(0, lat);
        check("nowrap_valid", slot_valid, 4'b0000);

        // Slow ROM: ack after three wait cycles, request held steady.
        park_all();
        set_sprite(2, 40, 95);
        sprite_frame = 5'b00100;
        ack_delay = 3;
        base_r = req_cycles;
        base_u = unstable;
        start_line(100);
        wait_done(0, lat);
        ack_delay = 0;
        check("slow_latency", lat, 11);
        check("slow_req_cycles", req_cycles - base_r, 4);
        check("slow_req_stable", unstable - base_u, 0);
        check("slow_mask", slot_mask[19:0], exp_mask(3'd2, 1'b1, 5'd5));

        // line_start mid-scan with changed inputs: ignored, flagged, line unchanged.
        park_all();
        set_sprite(2, 40, 95);
        sprite_frame = 5'b00100;
        start_line(100);
        step();
        for (int i = 0; i < NUM_SPRITES; i++) set_sprite(i, 600, 495);
        sprite_frame = '1;
        next_y     = 10'd500;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("midscan_missed", missed_line, 1'b1);
        wait_done(2, lat);
        check("midscan_latency", lat, 8);
        check("midscan_valid", slot_valid, 4'b0001);
        check("midscan_x", slot_x[9:0], 10'd40);
        check("midscan_mask", slot_mask[19:0], exp_mask(3'd2, 1'b1, 5'd5));
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) extra_done++;
        end
        check("midscan_no_second_line", extra_done, 0);
        check("midscan_missed_sticky", missed_line, 1'b1);

        // Reset while stuck in FETCH.
        park_all();
        set_sprite(0, 12, 95);
        rom_en = 1'b0;
        start_line(100);
        for (int i = 0; i < 20 && !rom_req; i++) step();
        check("stuck_req_high", rom_req, 1'b1);
        reset = 1'b1;
        step();
        check("fetch_reset_req", rom_req, 1'b0);
        check("fetch_reset_busy", busy, 1'b0);
        check("fetch_reset_valid", slot_valid, 4'b0000);
        check("fetch_reset_mask", slot_mask, {(MAX_SLOTS*TILE_SIZE){1'b0}});
        check("fetch_reset_missed", missed_line, 1'b0);
        reset  = 1'b0;
        rom_en = 1'b1;
        step();

        // Recovery after reset.
        start_line(100);
        wait_done(0, lat);
        check("recover_latency", lat, 8);
        check("recover_valid", slot_valid, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
